// File: rtl/arbitro_escrita_banco_if.sv
// Write-request and bank-write signal bundle between the two producers and
// the register-bank write arbiter.
interface arbitro_escrita_banco_if #(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 3
);
    logic                          Valid0;
    logic                          Valid1;
    logic [LARGURA_END-1:0]        Reg0;
    logic [LARGURA_END-1:0]        Reg1;
    logic [LARGURA_DADO-1:0]       Dado0;
    logic [LARGURA_DADO-1:0]       Dado1;
    logic                          Ready0;
    logic                          Ready1;
    logic                          RegWrite;
    logic [LARGURA_END-1:0]        RegEscr;
    logic [LARGURA_DADO-1:0]       DadoEscr;
    logic [(1<<LARGURA_END)-1:0]   Pendente;
    logic                          Ocioso;

    modport master (
        output Valid0, Valid1, Reg0, Reg1, Dado0, Dado1,
        input  Ready0, Ready1, RegWrite, RegEscr, DadoEscr, Pendente, Ocioso
    );

    modport slave (
        input  Valid0, Valid1, Reg0, Reg1, Dado0, Dado1,
        output Ready0, Ready1, RegWrite, RegEscr, DadoEscr, Pendente, Ocioso
    );
endinterface

// File: rtl/arbitro_escrita_banco.sv
// Round-robin write-port arbiter for the register bank: two 2-entry request
// FIFOs, one registered bank write per cycle, and a per-register pending mask.
module arbitro_escrita_banco #(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 3
) (
    input logic                    Clock,
    input logic                    ResetN,
    arbitro_escrita_banco_if.slave bus
);
    localparam int NUM_REGS = 1 << LARGURA_END;

    logic [LARGURA_END-1:0]  fifoReg  [2][2];
    logic [LARGURA_DADO-1:0] fifoDado [2][2];
    logic [1:0]              ocup     [2];
    logic [1:0]              rdPtr;
    logic [1:0]              wrPtr;
    logic                    ultimo;

    logic [LARGURA_END-1:0]  regIn  [2];
    logic [LARGURA_DADO-1:0] dadoIn [2];
    logic [1:0]              valid;
    logic [1:0]              ready;
    logic [1:0]              naoVazia;
    logic [1:0]              push;
    logic [1:0]              pop;
    logic                    grant;
    logic                    doGrant;

    logic                    regWrite;
    logic [LARGURA_END-1:0]  regEscr;
    logic [LARGURA_DADO-1:0] dadoEscr;
    logic [NUM_REGS-1:0]     pendente;
    logic                    slotOk;

    always_comb begin
        valid     = {bus.Valid1, bus.Valid0};
        regIn[0]  = bus.Reg0;
        regIn[1]  = bus.Reg1;
        dadoIn[0] = bus.Dado0;
        dadoIn[1] = bus.Dado1;
        for (int unsigned i = 0; i < 2; i++) begin
            ready[i]    = (ocup[i] != 2'd2);
            naoVazia[i] = (ocup[i] != 2'd0);
            push[i]     = valid[i] && ready[i];
        end
    end

    // With a single non-empty FIFO it wins outright; under contention the
    // requester that was not served last time goes first.
    always_comb begin
        doGrant = |naoVazia;
        grant   = (&naoVazia) ? ~ultimo : ~naoVazia[0];
        pop     = '0;
        if (doGrant) begin
            pop[grant] = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int unsigned i = 0; i < 2; i++) begin
                for (int unsigned s = 0; s < 2; s++) begin
                    fifoReg[i][s]  <= '0;
                    fifoDado[i][s] <= '0;
                end
                ocup[i] <= '0;
            end
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (push[i]) begin
                    fifoReg[i][wrPtr[i]]  <= regIn[i];
                    fifoDado[i][wrPtr[i]] <= dadoIn[i];
                    wrPtr[i]              <= ~wrPtr[i];
                end
                if (pop[i]) begin
                    rdPtr[i] <= ~rdPtr[i];
                end
                ocup[i] <= ocup[i] + 2'(push[i]) - 2'(pop[i]);
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            regWrite <= 1'b0;
            regEscr  <= '0;
            dadoEscr <= '0;
            ultimo   <= 1'b1;
        end else begin
            regWrite <= doGrant;
            if (doGrant) begin
                regEscr  <= fifoReg[grant][rdPtr[grant]];
                dadoEscr <= fifoDado[grant][rdPtr[grant]];
                ultimo   <= grant;
            end
        end
    end

    // A slot holds a live entry if the FIFO is full, or it is the head of a
    // single-entry FIFO.
    always_comb begin
        pendente = '0;
        slotOk   = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                slotOk = (ocup[i] == 2'd2) ||
                         ((ocup[i] == 2'd1) && (rdPtr[i] == 1'(s)));
                if (slotOk) begin
                    pendente[fifoReg[i][s]] = 1'b1;
                end
            end
        end
        if (regWrite) begin
            pendente[regEscr] = 1'b1;
        end
    end

    assign bus.Ready0   = ready[0];
    assign bus.Ready1   = ready[1];
    assign bus.RegWrite = regWrite;
    assign bus.RegEscr  = regEscr;
    assign bus.DadoEscr = dadoEscr;
    assign bus.Pendente = pendente;
    assign bus.Ocioso   = ~naoVazia[0] & ~naoVazia[1] & ~regWrite;
endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// Scoreboard bench for arbitro_escrita_banco: a queue-based model predicts
// bank writes, a monitor compares every cycle's outputs against it.
module tb_arbitro_escrita_banco;
    typedef struct packed {
        logic [2:0] r;
        logic [7:0] d;
    } entrada_t;

    logic Clock  = 1'b0;
    logic ResetN = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    entrada_t q0[$];
    entrada_t q1[$];
    entrada_t expQ[$];
    logic       mRegWrite = 1'b0;
    logic [2:0] mEscr     = '0;
    logic [7:0] mDado     = '0;
    int         ultimo    = 1;

    arbitro_escrita_banco_if #(.LARGURA_DADO(8), .LARGURA_END(3)) bus ();

    arbitro_escrita_banco #(.LARGURA_DADO(8), .LARGURA_END(3)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual !== esperado) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic [7:0] pendModelo();
        logic [7:0] p;
        p = '0;
        foreach (q0[k]) p[q0[k].r] = 1'b1;
        foreach (q1[k]) p[q1[k].r] = 1'b1;
        if (mRegWrite) p[mEscr] = 1'b1;
        return p;
    endfunction

    // Reference: two bounded queues, alternate service under contention,
    // heads taken before this edge's pushes are appended.
    always @(posedge Clock or negedge ResetN) begin : modelo
        entrada_t e;
        bit a0, a1;
        int g;
        if (!ResetN) begin
            q0.delete();
            q1.delete();
            expQ.delete();
            mRegWrite = 1'b0;
            mEscr     = '0;
            mDado     = '0;
            ultimo    = 1;
        end else begin
            a0 = (bus.Valid0 === 1'b1) && (q0.size() < 2);
            a1 = (bus.Valid1 === 1'b1) && (q1.size() < 2);
            g  = -1;
            if (q0.size() > 0 && q1.size() > 0) g = 1 - ultimo;
            else if (q0.size() > 0)            g = 0;
            else if (q1.size() > 0)            g = 1;
            if (g == 0) e = q0.pop_front();
            if (g == 1) e = q1.pop_front();
            if (g >= 0) begin
                expQ.push_back(e);
                mRegWrite = 1'b1;
                mEscr     = e.r;
                mDado     = e.d;
                ultimo    = g;
            end else begin
                mRegWrite = 1'b0;
            end
            if (a0) q0.push_back({bus.Reg0, bus.Dado0});
            if (a1) q1.push_back({bus.Reg1, bus.Dado1});
        end
    end

    always @(posedge Clock) begin : monitor
        entrada_t e;
        #1;
        check("regwrite", bus.RegWrite, mRegWrite);
        if (bus.RegWrite === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got reg %0d data %0h expected no write", bus.RegEscr, bus.DadoEscr);
            end else begin
                e = expQ.pop_front();
                check("write_reg", bus.RegEscr, e.r);
                check("write_data", bus.DadoEscr, e.d);
            end
        end else begin
            check("hold_reg", bus.RegEscr, mEscr);
            check("hold_data", bus.DadoEscr, mDado);
        end
        check("ready0", bus.Ready0, q0.size() < 2);
        check("ready1", bus.Ready1, q1.size() < 2);
        check("pendente", bus.Pendente, pendModelo());
        check("ocioso", bus.Ocioso, (q0.size() == 0) && (q1.size() == 0) && !mRegWrite);
    end

    task automatic drive(input bit v0, input logic [2:0] r0, input logic [7:0] d0,
                         input bit v1, input logic [2:0] r1, input logic [7:0] d1);
        @(negedge Clock);
        bus.Valid0 = v0; bus.Reg0 = r0; bus.Dado0 = d0;
        bus.Valid1 = v1; bus.Reg1 = r1; bus.Dado1 = d1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        bus.Valid0 = 1'b0; bus.Reg0 = '0; bus.Dado0 = '0;
        bus.Valid1 = 1'b0; bus.Reg1 = '0; bus.Dado1 = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        #1;
        check("reset_ready0", bus.Ready0, 1);
        check("reset_ready1", bus.Ready1, 1);
        check("reset_ocioso", bus.Ocioso, 1);
        check("reset_regescr", bus.RegEscr, 0);

        // single write to r3
        drive(1'b1, 3'd3, 8'hA5, 1'b0, '0, '0);
        idle(4);

        // contention: 1,5,2,6,3,7
        for (int k = 1; k <= 3; k++)
            drive(1'b1, 3'(k), 8'(8'h10 + k), 1'b1, 3'(k + 4), 8'(8'h50 + k));
        idle(8);

        // backpressure: both saturating, req1 offered for 4 cycles
        for (int k = 0; k < 8; k++)
            drive(1'b1, 3'(k), 8'(8'h20 + k), k < 4, 3'(7 - k), 8'(8'h60 + k));
        idle(8);

        // steady push/pop on FIFO0 at occupancy 1
        for (int k = 0; k < 6; k++)
            drive(1'b1, 3'(k + 1), 8'(8'h30 + k), 1'b0, '0, '0);
        idle(6);

        // randomized traffic with varying load
        for (int k = 0; k < 400; k++) begin
            int p;
            p = (k < 200) ? 40 : 90;
            drive($urandom_range(0, 99) < p, 3'($urandom), 8'($urandom),
                  $urandom_range(0, 99) < p, 3'($urandom), 8'($urandom));
        end
        idle(10);
        check("drained", q0.size() + q1.size() + expQ.size(), 0);

        // reset in mid-cycle while both FIFOs hold traffic
        for (int k = 0; k < 5; k++)
            drive(1'b1, 3'(k), 8'($urandom), 1'b1, 3'(k + 3), 8'($urandom));
        @(negedge Clock);
        bus.Valid0 = 1'b0;
        bus.Valid1 = 1'b0;
        #2 ResetN = 1'b0;
        #1;
        check("midreset_regwrite", bus.RegWrite, 0);
        check("midreset_pendente", bus.Pendente, 0);
        check("midreset_ready0", bus.Ready0, 1);
        check("midreset_ready1", bus.Ready1, 1);
        check("midreset_ocioso", bus.Ocioso, 1);
        check("midreset_regescr", bus.RegEscr, 0);
        @(negedge Clock);
        ResetN = 1'b1;
        idle(5);

        // one last write, then idle with held outputs
        drive(1'b0, '0, '0, 1'b1, 3'd6, 8'hC3);
        idle(5);
        check("final_ocioso", bus.Ocioso, 1);
        check("final_hold_reg", bus.RegEscr, 6);
        check("final_hold_data", bus.DadoEscr, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
